// File: rtl/cellram_ctrl_pkg.sv
// cellram_ctrl_pkg: shared FSM state type, default timing constants and wait-counter width helper
//   for the CellularRAM asynchronous controller.
package cellram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD_ACT, WR_SETUP, WR_ACT, WR_HOLD, REC} state_e;
  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 16;
  localparam int T_RD_DEF   = 4;
  localparam int T_WR_DEF   = 4;
  localparam int T_REC_DEF  = 1;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/cellram_async_ctrl_if.sv
// cellram_async_ctrl_if: single-word request/response bus between the SoC and the CellularRAM controller.
//   master (SoC side): drives req, req_we, req_addr, req_wdata (and req_be when CELLRAM_BYTE_EN_EN);
//                      sees req_ready, done, rdata.
//   slave (controller side): the mirror image.
interface cellram_async_ctrl_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
`ifdef CELLRAM_BYTE_EN_EN
  logic [1:0]        req_be;
  modport master (output req, req_we, req_addr, req_wdata, req_be, input req_ready, done, rdata);
  modport slave  (input req, req_we, req_addr, req_wdata, req_be, output req_ready, done, rdata);
`else
  modport master (output req, req_we, req_addr, req_wdata, input req_ready, done, rdata);
  modport slave  (input req, req_we, req_addr, req_wdata, output req_ready, done, rdata);
`endif
endinterface

// File: rtl/cellram_wait_timer.sv
// cellram_wait_timer: loadable down-counter timing each controller state.
//   clk, reset : clock, synchronous active-high reset
//   load       : load value into the counter (state entry)
//   value      : cycle count for the state being entered
//   expire     : high on the last cycle of the loaded interval (count at 1)
module cellram_wait_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  // Stops at 1 rather than wrapping so an idle timer keeps reporting expiry.
  always_comb cnt_d = load ? value : (cnt_q > W'(1) ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign expire = cnt_q <= W'(1);
endmodule

// File: rtl/cellram_async_ctrl.sv
// cellram_async_ctrl: sequences asynchronous single-word read/write cycles on an external CellularRAM.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave modport) : req/req_we/req_addr/req_wdata[/req_be] in; req_ready/done/rdata out
//   mem_ce_n/oe_n/we_n  : registered active-low strobes
//   mem_lb_n/mem_ub_n   : byte lane enables (constant 0 unless CELLRAM_BYTE_EN_EN is defined)
//   mem_addr            : registered word address
//   mem_dq              : bidirectional data, driven only through WR_SETUP/WR_ACT/WR_HOLD
//   Optional feature macro: CELLRAM_BYTE_EN_EN (adds req_be, drives lane enables from it).
module cellram_async_ctrl
  import cellram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_RD   = T_RD_DEF,
  parameter int T_WR   = T_WR_DEF,
  parameter int T_REC  = T_REC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  cellram_async_ctrl_if.slave    bus,
  output logic                   mem_ce_n,
  output logic                   mem_oe_n,
  output logic                   mem_we_n,
  output logic                   mem_lb_n,
  output logic                   mem_ub_n,
  output logic [ADDR_W-1:0]      mem_addr,
  inout  wire  [DATA_W-1:0]      mem_dq
);
  localparam int CW = cnt_w(T_RD, T_WR, T_REC);
  state_e            state_q, state_d;
  logic              accept, load, expire;
  logic [CW-1:0]     load_val;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  cellram_wait_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .value  (load_val),
    .expire (expire)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    accept  = (state_q == IDLE) && bus.req;
    unique case (state_q)
      IDLE:     if (bus.req) state_d = bus.req_we ? WR_SETUP : RD_ACT;
      RD_ACT:   if (expire) state_d = REC;
      WR_SETUP: if (expire) state_d = WR_ACT;
      WR_ACT:   if (expire) state_d = WR_HOLD;
      WR_HOLD:  if (expire) state_d = REC;
      REC:      if (expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    load     = state_d != state_q;
    load_val = state_d == RD_ACT ? CW'(T_RD) :
               state_d == WR_ACT ? CW'(T_WR) :
               state_d == REC    ? CW'(T_REC) : CW'(1);
    // Strobes are decoded from the next state and registered, so pads see no path from req_*.
    ce_n_d   = (state_d == IDLE) || (state_d == REC);
    oe_n_d   = state_d != RD_ACT;
    we_n_d   = state_d != WR_ACT;
    dq_oe_d  = (state_d == WR_SETUP) || (state_d == WR_ACT) || (state_d == WR_HOLD);
    addr_d   = accept ? bus.req_addr : addr_q;
    wdata_d  = accept ? bus.req_wdata : wdata_q;
    rdata_d  = (state_q == RD_ACT && expire) ? mem_dq : rdata_q;
    done_d   = (state_d == REC) && (state_q != REC);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef CELLRAM_BYTE_EN_EN
  logic [1:0] be_q, be_d;
  logic       lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  always_comb begin
    be_d   = accept ? bus.req_be : be_q;
    lb_n_d = ce_n_d | ~be_d[0];
    ub_n_d = ce_n_d | ~be_d[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      be_q   <= 2'b00;
      lb_n_q <= 1'b1;
      ub_n_q <= 1'b1;
    end else begin
      be_q   <= be_d;
      lb_n_q <= lb_n_d;
      ub_n_q <= ub_n_d;
    end
  end
  assign mem_lb_n = lb_n_q;
  assign mem_ub_n = ub_n_q;
`else
  assign mem_lb_n = 1'b0;
  assign mem_ub_n = 1'b0;
`endif
  assign mem_ce_n      = ce_n_q;
  assign mem_oe_n      = oe_n_q;
  assign mem_we_n      = we_n_q;
  assign mem_addr      = addr_q;
  assign mem_dq        = dq_oe_q ? wdata_q : 'z;
  assign bus.req_ready = state_q == IDLE;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
endmodule
